// File: rtl/multiplier_combined_pipe.sv
// multiplier_combined_pipe
//   Pipelined multi-mode unsigned multiplier for the combined DSP datapath.
//   mode 0: two independent SUB_A x SUB_B lane products
//           (lane 0 from IN1, lane 1 from IN2).
//   mode 1: one BIG_W x BIG_W product of IN1/IN2 low bits, zero-extended.
//   Every operand set carries its own mode/acc_clr tags, so the mode may
//   change on every cycle without flushing the pipe.
//   Latency is PIPE_STAGES enabled edges.
//   Optional macro MULT_ACC_EN adds an accumulator stage, giving PIPE_STAGES+1.
// Ports
//   clk, reset (async, active high), ena (global clock enable)
//   in_valid, mode, acc_clr, IN1, IN2 : operand set plus its tags
//   out_valid, OUT1                   : product, or accumulator value

// Unsigned A_W x B_W multiplier.
// Operands are split into 9-bit chunks, and the partial products are summed
// with shifts. The true product fits in P_W, so truncating the sum is exact.
module multiplier_combined_pipe_pp #(
  parameter  int A_W = 18,
  parameter  int B_W = 19,
  localparam int P_W = A_W + B_W
) (
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [P_W-1:0] p
);
  localparam int NA   = (A_W + 8) / 9;
  localparam int NB   = (B_W + 8) / 9;
  localparam int PA_W = NA * 9;
  localparam int PB_W = NB * 9;
  localparam int PADW = PA_W + PB_W;

  logic [PA_W-1:0]         a_pad;
  logic [PB_W-1:0]         b_pad;
  logic [NA*NB-1:0][17:0]  pp;

  assign a_pad = PA_W'(a);
  assign b_pad = PB_W'(b);

  for (genvar i = 0; i < NA; i++) begin : g_a
    for (genvar j = 0; j < NB; j++) begin : g_b
      assign pp[i*NB+j] = 18'(a_pad[9*i +: 9]) * 18'(b_pad[9*j +: 9]);
    end
  end

  always_comb begin
    p = '0;
    for (int i = 0; i < NA; i++)
      for (int j = 0; j < NB; j++)
        p = p + P_W'(PADW'(pp[i*NB+j]) << (9 * (i + j)));
  end
endmodule

module multiplier_combined_pipe #(
  parameter  int SUB_A       = 18,
  parameter  int SUB_B       = 19,
  parameter  int BIG_W       = 27,
  parameter  int PIPE_STAGES = 3,
  localparam int IN_W        = SUB_A + SUB_B,
  localparam int OUT_W       = 2 * IN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic             in_valid,
  input  logic             mode,
  input  logic             acc_clr,
  input  logic [IN_W-1:0]  IN1,
  input  logic [IN_W-1:0]  IN2,
  output logic             out_valid,
  output logic [OUT_W-1:0] OUT1
);
  localparam int NUM_LANES = 2;

  typedef struct packed {
    logic mode;
    logic clr;
  } tag_t;

  typedef logic [NUM_LANES-1:0][IN_W-1:0] lanes_t;

  logic [PIPE_STAGES:1] vld_pipe;
  tag_t [PIPE_STAGES:1] tag_pipe;
  lanes_t               op_q;                  // stage 1: [0]=IN1, [1]=IN2
  lanes_t [PIPE_STAGES:2] res_pipe;

  lanes_t               lane_p;
  logic [2*BIG_W-1:0]   big_p;
  lanes_t               prod;

  // The lane multipliers and the big multiplier share the stage-1 operands.
  // The stage-1 mode tag picks which result enters the product stage.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    multiplier_combined_pipe_pp #(.A_W(SUB_A), .B_W(SUB_B)) u_pp (
      .a (op_q[l][SUB_A-1:0]),
      .b (op_q[l][IN_W-1:SUB_A]),
      .p (lane_p[l])
    );
  end

  multiplier_combined_pipe_pp #(.A_W(BIG_W), .B_W(BIG_W)) u_big (
    .a (op_q[0][BIG_W-1:0]),
    .b (op_q[1][BIG_W-1:0]),
    .p (big_p)
  );

  assign prod = tag_pipe[1].mode ? lanes_t'(OUT_W'(big_p)) : lane_p;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
      op_q     <= '0;
      res_pipe <= '0;
    end else if (ena) begin
      vld_pipe[1] <= in_valid;
      tag_pipe[1] <= {mode, acc_clr};
      op_q        <= {IN2, IN1};
      res_pipe[2] <= prod;
      for (int s = 2; s <= PIPE_STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        tag_pipe[s] <= tag_pipe[s-1];
      end
      for (int s = 3; s <= PIPE_STAGES; s++)
        res_pipe[s] <= res_pipe[s-1];
    end
  end

`ifdef MULT_ACC_EN
  lanes_t acc_q;
  lanes_t acc_sum;
  logic   acc_vld;

  // In mode 1 the full word wraps modulo 2^OUT_W.
  // In mode 0 each lane wraps on its own.
  // The layout is shared, so a mode change simply reinterprets acc_q.
  always_comb begin
    acc_sum = '0;
    if (tag_pipe[PIPE_STAGES].mode)
      acc_sum = acc_q + res_pipe[PIPE_STAGES];
    else
      for (int l = 0; l < NUM_LANES; l++)
        acc_sum[l] = acc_q[l] + res_pipe[PIPE_STAGES][l];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      acc_vld <= 1'b0;
    end else if (ena) begin
      acc_vld <= vld_pipe[PIPE_STAGES];
      if (vld_pipe[PIPE_STAGES])
        acc_q <= tag_pipe[PIPE_STAGES].clr ? res_pipe[PIPE_STAGES] : acc_sum;
    end
  end

  assign out_valid = acc_vld;
  assign OUT1      = acc_q;
`else
  assign out_valid = vld_pipe[PIPE_STAGES];
  assign OUT1      = res_pipe[PIPE_STAGES];

  // Without the accumulator, the late tags and the clear bit have no consumer.
  logic unused_tags;
  assign unused_tags = ^{tag_pipe[PIPE_STAGES:2], tag_pipe[1].clr};
`endif
endmodule

// File: tb/tb_multiplier_combined_pipe.sv
// tb_multiplier_combined_pipe
//   Random and directed stimulus against a transaction-level reference model.
//   The model computes each product with plain arithmetic and queues it with
//   its due time (counted in enabled edges). Every sample is checked for the
//   due result, a bubble, or a held output while ena=0.
//   Define MULT_ACC_EN to exercise the accumulator build.
//   Override PIPE_STAGES to run the 2/3/4 variants.
module tb_multiplier_combined_pipe;
  parameter int PIPE_STAGES = 3;
  localparam int SUB_A = 18, SUB_B = 19, BIG_W = 27;
  localparam int IN_W  = SUB_A + SUB_B;
  localparam int OUT_W = 2 * IN_W;
`ifdef MULT_ACC_EN
  localparam int LAT = PIPE_STAGES + 1;
`else
  localparam int LAT = PIPE_STAGES;
`endif

  typedef struct {
    logic [OUT_W-1:0] prod;
    logic             mode;
    logic             clr;
    int               due;
  } txn_t;

  logic             clk, reset, ena, in_valid, mode, acc_clr;
  logic [IN_W-1:0]  IN1, IN2;
  logic             out_valid;
  logic [OUT_W-1:0] OUT1;

  int   n_chk, n_fail, edge_cnt;
  txn_t q[$];
`ifdef MULT_ACC_EN
  logic [OUT_W-1:0] acc_m;
`endif

  multiplier_combined_pipe #(
    .SUB_A(SUB_A), .SUB_B(SUB_B), .BIG_W(BIG_W), .PIPE_STAGES(PIPE_STAGES)
  ) dut (
    .clk(clk), .reset(reset), .ena(ena), .in_valid(in_valid), .mode(mode),
    .acc_clr(acc_clr), .IN1(IN1), .IN2(IN2), .out_valid(out_valid), .OUT1(OUT1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] ref_prod(input logic m, input logic [IN_W-1:0] a,
                                                input logic [IN_W-1:0] b);
    logic [OUT_W-1:0] lo, hi;
    if (m) return OUT_W'(a[BIG_W-1:0]) * OUT_W'(b[BIG_W-1:0]);
    lo = OUT_W'(a[SUB_A-1:0]) * OUT_W'(a[IN_W-1:SUB_A]);
    hi = OUT_W'(b[SUB_A-1:0]) * OUT_W'(b[IN_W-1:SUB_A]);
    return (hi << IN_W) | lo;
  endfunction

  function automatic logic [IN_W-1:0] rnd();
    return IN_W'({$urandom(), $urandom()});
  endfunction

  // Expected OUT1 when a transaction emerges (the accumulator model updates here).
  task automatic model_out(input txn_t t, output logic [OUT_W-1:0] exp);
`ifdef MULT_ACC_EN
    if (t.clr)       acc_m = t.prod;
    else if (t.mode) acc_m = acc_m + t.prod;
    else             acc_m = {acc_m[OUT_W-1:IN_W] + t.prod[OUT_W-1:IN_W],
                              acc_m[IN_W-1:0]    + t.prod[IN_W-1:0]};
    exp = acc_m;
`else
    exp = t.prod;
`endif
  endtask

  // One clock cycle: drive, clock, then check one sample 1 time unit after the edge.
  task automatic cyc(input logic e, input logic v, input logic m, input logic c,
                     input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
    logic             ov0;
    logic [OUT_W-1:0] o0, exp;
    txn_t             t;
    ov0 = out_valid;
    o0  = OUT1;
    ena = e; in_valid = v; mode = m; acc_clr = c; IN1 = a; IN2 = b;
    @(posedge clk); #1;
    if (e) begin
      edge_cnt++;
      if (v) q.push_back('{prod: ref_prod(m, a, b), mode: m, clr: c, due: edge_cnt + LAT - 1});
      if (q.size() > 0 && q[0].due == edge_cnt) begin
        t = q.pop_front();
        model_out(t, exp);
        chk("out_valid", OUT_W'(out_valid), OUT_W'(1));
        chk("OUT1", OUT1, exp);
      end else begin
        chk("bubble_valid", OUT_W'(out_valid), '0);
      end
    end else begin
      chk("hold_valid", OUT_W'(out_valid), OUT_W'(ov0));
      chk("hold_OUT1", OUT1, o0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_async_valid", OUT_W'(out_valid), '0);
    chk("rst_async_OUT1", OUT1, '0);
    @(posedge clk); #1;
    chk("rst_hold_valid", OUT_W'(out_valid), '0);
    chk("rst_hold_OUT1", OUT1, '0);
    reset = 1'b0;
    q.delete();
`ifdef MULT_ACC_EN
    acc_m = '0;
`endif
  endtask

  initial begin
    int sent;
    logic m;
    n_chk = 0; n_fail = 0; edge_cnt = 0;
    reset = 1'b1; ena = 1'b0; in_valid = 1'b0; mode = 1'b0; acc_clr = 1'b0;
    IN1 = '0; IN2 = '0;
`ifdef MULT_ACC_EN
    acc_m = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", OUT_W'(out_valid), '0);
    chk("reset_OUT1", OUT1, '0);
    reset = 1'b0;

    // Directed mode 0: small lane and all-ones lane.
    cyc(1'b1, 1'b1, 1'b0, 1'b1, {19'd3, 18'd5}, {19'h7FFFF, 18'h3FFFF});
    idle(LAT + 1);

    // Directed mode 1: 27-bit all-ones squared; upper operand bits are random.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, {10'($urandom()), 27'h7FFFFFF}, {10'($urandom()), 27'h7FFFFFF});
    idle(LAT + 1);

    // 64 back-to-back operand sets with the mode alternating every cycle.
    for (int i = 0; i < 64; i++)
      cyc(1'b1, 1'b1, 1'(i), 1'($urandom_range(0, 1)), rnd(), rnd());
    idle(LAT + 1);

    // Stream of 10 valid operand sets, with ena toggled pseudo-randomly.
    // in_valid stays high on ena=0 cycles, and those operands must not be taken.
    sent = 0;
    for (int k = 0; k < 400 && sent < 10; k++) begin
      m = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        cyc(1'b1, 1'b1, m, 1'($urandom_range(0, 1)), rnd(), rnd());
        sent++;
      end else begin
        cyc(1'b0, 1'b1, m, 1'b0, rnd(), rnd());
      end
    end
    chk("ena_stream_sent", OUT_W'(sent), OUT_W'(10));
    for (int k = 0; k < 3 * LAT; k++)
      cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, '0, '0);
    idle(LAT + 1);

    // Random traffic with bubbles.
    for (int i = 0; i < 40; i++)
      cyc(1'b1, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) == 0), rnd(), rnd());
    idle(LAT + 1);

    // Reset with three results in flight. After the reset, the next operand
    // set must arrive at the normal latency.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b1, 1'(i), 1'b1, rnd(), rnd());
    pulse_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b1, rnd(), rnd());
    idle(LAT + 2);

`ifdef MULT_ACC_EN
    // Mode 1 accumulation: 2x3 (load), then add 4x5, then add 1x1.
    // Expected sequence: 6, 26, 27.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 37'd2, 37'd3);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 37'd4, 37'd5);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 37'd1, 37'd1);
    idle(LAT + 1);
    // Mode 0: lane 0 is brought to 2^37-1, then 1 is added and it wraps to 0.
    // Lane 1 accumulates 12 + 30 + 0 and must not see a carry.
    cyc(1'b1, 1'b1, 1'b0, 1'b1, {19'h7FFFF, 18'h3FFFF}, {19'd4, 18'd3});
    cyc(1'b1, 1'b1, 1'b0, 1'b0, {19'd393215, 18'd2},   {19'd6, 18'd5});
    cyc(1'b1, 1'b1, 1'b0, 1'b0, {19'd1, 18'd1},        {19'd0, 18'd0});
    idle(LAT + 1);
    // Mode change without a clear: add a mode-1 product on top of the lane state.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, rnd(), rnd());
    idle(LAT + 1);
`endif

    idle(LAT + 2);
    chk("drained", OUT_W'(q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
